// File: rtl/sop_truth_engine_if.sv
// Bus bundle for sop_truth_engine: config write port, evaluation port and scan engine.
// The master drives requests; the slave (the engine) drives responses.
interface sop_truth_engine_if #(
  parameter int NVARS = 4,
  parameter int NFUNC = 2,
  parameter int FSELW = (NFUNC > 1) ? $clog2(NFUNC) : 1
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [FSELW-1:0] cfg_func;
  logic [NVARS-1:0] cfg_addr;
  logic             cfg_data;

  logic             in_valid;
  logic [NVARS-1:0] in_vars;
  logic             out_valid;
  logic [NFUNC-1:0] out_f;

  logic             scan_start;
  logic [FSELW-1:0] scan_func;
  logic             scan_busy;
  logic             scan_done;
  logic [NVARS:0]   scan_count;
  logic [NVARS-1:0] scan_first;
  logic             scan_none;

  modport master (
    output cfg_valid, cfg_func, cfg_addr, cfg_data,
    output in_valid, in_vars,
    output scan_start, scan_func,
    input  cfg_ready, out_valid, out_f,
    input  scan_busy, scan_done, scan_count, scan_first, scan_none
  );

  modport slave (
    input  cfg_valid, cfg_func, cfg_addr, cfg_data,
    input  in_valid, in_vars,
    input  scan_start, scan_func,
    output cfg_ready, out_valid, out_f,
    output scan_busy, scan_done, scan_count, scan_first, scan_none
  );
endinterface

// File: rtl/sop_truth_engine.sv
// Programmable sum-of-products engine: NFUNC bit-writable truth tables, registered
// parallel evaluation, and a scan FSM reporting minterm count and lowest minterm.
module sop_truth_engine #(
  parameter int NVARS = 4,
  parameter int NFUNC = 2,
  parameter int FSELW = (NFUNC > 1) ? $clog2(NFUNC) : 1
) (
  input logic               clk,
  input logic               rst,
  sop_truth_engine_if.slave bus
);
  localparam int DEPTH = 1 << NVARS;
  localparam int NROWS = 1 << FSELW;

  // state | meaning
  // IDLE  | waiting for scan_start, config writes accepted
  // SCAN  | walking one table entry per cycle, config writes blocked
  // DONE  | one-cycle result pulse, then back to IDLE
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t           state, state_nxt;
  logic [NVARS-1:0] idx, idx_nxt;
  logic [NVARS:0]   cnt, cnt_nxt;
  logic [NVARS-1:0] first, first_nxt;
  logic             found, found_nxt;
  logic [FSELW-1:0] sel, sel_nxt;
  logic             latch_res;

  logic [NVARS:0]   res_count;
  logic [NVARS-1:0] res_first;
  logic             res_none;
  logic             out_valid_q;
  logic [NFUNC-1:0] out_f_q;

  logic             wr_go;
  logic [NFUNC-1:0] eval_bits;
  logic [NROWS-1:0] scan_bits;
  logic             scan_bit;

  assign wr_go = bus.cfg_valid && bus.cfg_ready;

  // Select codes beyond NFUNC map to constant-zero rows, so writes to them vanish
  // and scanning them sees an empty table.
  for (genvar k = 0; k < NROWS; k++) begin : g_row
    if (k < NFUNC) begin : g_live
      logic [DEPTH-1:0] row;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          row <= '0;
        end else if (wr_go && (bus.cfg_func == FSELW'(k))) begin
          row[bus.cfg_addr] <= bus.cfg_data;
        end
      end
      assign eval_bits[k] = row[bus.in_vars];
      assign scan_bits[k] = row[idx];
    end else begin : g_dead
      assign scan_bits[k] = 1'b0;
    end
  end

  assign scan_bit = scan_bits[sel];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        out_f_q <= eval_bits;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      first     <= '0;
      found     <= 1'b0;
      sel       <= '0;
      res_count <= '0;
      res_first <= '0;
      res_none  <= 1'b0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cnt   <= cnt_nxt;
      first <= first_nxt;
      found <= found_nxt;
      sel   <= sel_nxt;
      // Results take the post-last-index values so they are valid during DONE.
      if (latch_res) begin
        res_count <= cnt_nxt;
        res_first <= first_nxt;
        res_none  <= !found_nxt;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    first_nxt = first;
    found_nxt = found;
    sel_nxt   = sel;
    latch_res = 1'b0;
    case (state)
      IDLE: begin
        if (bus.scan_start) begin
          state_nxt = SCAN;
          sel_nxt   = bus.scan_func;
          idx_nxt   = '0;
          cnt_nxt   = '0;
          first_nxt = '0;
          found_nxt = 1'b0;
        end
      end
      SCAN: begin
        idx_nxt = idx + 1'b1;
        if (scan_bit) begin
          cnt_nxt = cnt + 1'b1;
          if (!found) begin
            first_nxt = idx;
            found_nxt = 1'b1;
          end
        end
        if (&idx) begin
          state_nxt = DONE;
          latch_res = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.cfg_ready  = (state != SCAN);
  assign bus.scan_busy  = (state == SCAN);
  assign bus.scan_done  = (state == DONE);
  assign bus.out_valid  = out_valid_q;
  assign bus.out_f      = out_f_q;
  assign bus.scan_count = res_count;
  assign bus.scan_first = res_first;
  assign bus.scan_none  = res_none;

endmodule

// File: tb/tb_sop_truth_engine.sv
// Directed bench for sop_truth_engine: stimulus pushes hand-computed expectations into
// queues, a negedge monitor pops and compares on out_valid / scan_done.
module tb_sop_truth_engine;
  logic clk;
  logic rst;

  sop_truth_engine_if #(.NVARS(4), .NFUNC(2)) bus ();

  sop_truth_engine #(.NVARS(4), .NFUNC(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [4:0] cnt;
    logic [3:0] first;
    logic       none;
  } scan_exp_t;

  logic [1:0] eval_q[$];
  scan_exp_t  scan_q[$];
  logic [1:0] mon_e;
  scan_exp_t  mon_s;
  int tests;
  int fails;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.out_valid) begin
        if (eval_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL eval_unexpected: got out_f %0h, expected no result", bus.out_f);
        end else begin
          mon_e = eval_q.pop_front();
          check("eval_out_f", 32'(bus.out_f), 32'(mon_e));
        end
      end
      if (bus.scan_done) begin
        if (scan_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scan_done_unexpected: got count %0h, expected no pulse", bus.scan_count);
        end else begin
          mon_s = scan_q.pop_front();
          check("scan_count", 32'(bus.scan_count), 32'(mon_s.cnt));
          check("scan_first", 32'(bus.scan_first), 32'(mon_s.first));
          check("scan_none",  32'(bus.scan_none),  32'(mon_s.none));
        end
      end
    end
  end

  // All tasks start and end aligned to a falling edge.
  task automatic wr(input logic f, input logic [3:0] a, input logic d);
    bus.cfg_valid = 1'b1;
    bus.cfg_func  = f;
    bus.cfg_addr  = a;
    bus.cfg_data  = d;
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  task automatic eval(input logic [3:0] v, input logic [1:0] exp);
    bus.in_valid = 1'b1;
    bus.in_vars  = v;
    eval_q.push_back(exp);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_scan(input logic f, input logic [4:0] c, input logic [3:0] fst,
                          input logic none, input bit disturb, input int abort_at);
    int busy_n;
    int done_at;
    scan_exp_t s;
    s.cnt = c;
    s.first = fst;
    s.none = none;
    bus.scan_start = 1'b1;
    bus.scan_func  = f;
    if (abort_at == 0) scan_q.push_back(s);
    @(negedge clk);
    bus.scan_start = 1'b0;
    busy_n  = 0;
    done_at = 0;
    for (int n = 1; n <= 40; n++) begin
      if (abort_at == n) begin
        #2 rst = 1'b1;
        #1;
        check("abort_busy",  32'(bus.scan_busy), 0);
        check("abort_done",  32'(bus.scan_done), 0);
        check("abort_count", 32'(bus.scan_count), 0);
        check("abort_ready", 32'(bus.cfg_ready), 1);
        return;
      end
      if (bus.scan_busy) busy_n++;
      if (bus.scan_done) begin
        done_at = n;
        break;
      end
      if (disturb && n == 5) begin
        check("cfg_ready_in_scan", 32'(bus.cfg_ready), 0);
        bus.cfg_valid  = 1'b1;
        bus.cfg_func   = 1'b0;
        bus.cfg_addr   = 4'd3;
        bus.cfg_data   = 1'b0;
        bus.scan_start = 1'b1;
        bus.scan_func  = 1'b1;
      end
      if (disturb && n == 6) begin
        bus.cfg_valid  = 1'b0;
        bus.scan_start = 1'b0;
      end
      @(negedge clk);
    end
    check("scan_busy_cycles", 32'(busy_n), 16);
    check("scan_done_cycle", 32'(done_at), 17);
    @(negedge clk);
    check("scan_idle_after_done", 32'(bus.scan_busy | bus.scan_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int f1_ones[8] = '{0, 2, 5, 7, 8, 10, 12, 13};
    int f2_ones[8] = '{5, 13, 10, 11, 6, 7, 14, 15};
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.cfg_valid = 1'b0; bus.cfg_func = 1'b0; bus.cfg_addr = '0; bus.cfg_data = 1'b0;
    bus.in_valid = 1'b0; bus.in_vars = '0;
    bus.scan_start = 1'b0; bus.scan_func = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_f", 32'(bus.out_f), 0);
    check("rst_busy", 32'(bus.scan_busy), 0);
    check("rst_done", 32'(bus.scan_done), 0);
    check("rst_count", 32'(bus.scan_count), 0);
    check("rst_first", 32'(bus.scan_first), 0);
    check("rst_none", 32'(bus.scan_none), 0);
    rst = 1'b0;
    check("ready_after_rst", 32'(bus.cfg_ready), 1);

    // Mid-cycle asynchronous reset with a live result on the outputs
    wr(1'b0, 4'd0, 1'b1);
    eval(4'd0, 2'b01);
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", 32'(bus.out_valid), 0);
    check("async_out_f", 32'(bus.out_f), 0);
    check("async_busy", 32'(bus.scan_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    check("ready_after_async", 32'(bus.cfg_ready), 1);
    run_scan(1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 0);

    // f1 = b'd' + a'bd + abc'
    foreach (f1_ones[i]) wr(1'b0, 4'(f1_ones[i]), 1'b1);
    eval(4'b0101, 2'b01);
    eval(4'b0110, 2'b00);
    run_scan(1'b0, 5'd8, 4'd0, 1'b0, 1'b0, 0);

    // f2 = xy'z + wx'y + w'xy + wxy
    foreach (f2_ones[i]) wr(1'b1, 4'(f2_ones[i]), 1'b1);
    eval(4'b1011, 2'b10);
    @(negedge clk);
    check("hold_out_valid", 32'(bus.out_valid), 0);
    check("hold_out_f", 32'(bus.out_f), 32'h2);
    eval(4'b0101, 2'b11);

    // Write and evaluate the same address in one cycle: old contents seen
    bus.cfg_valid = 1'b1; bus.cfg_func = 1'b0; bus.cfg_addr = 4'd4; bus.cfg_data = 1'b1;
    bus.in_valid = 1'b1; bus.in_vars = 4'd4;
    eval_q.push_back(2'b00);
    @(negedge clk);
    bus.cfg_valid = 1'b0; bus.in_valid = 1'b0;
    eval(4'd4, 2'b01);
    wr(1'b0, 4'd4, 1'b0);
    run_scan(1'b1, 5'd8, 4'd5, 1'b0, 1'b0, 0);

    // All-ones table, plus blocked write and ignored restart during the scan
    for (int a = 0; a < 16; a++) wr(1'b0, 4'(a), 1'b1);
    run_scan(1'b0, 5'b10000, 4'd0, 1'b0, 1'b1, 0);
    eval(4'd3, 2'b01);

    // Reset at scan cycle 7
    run_scan(1'b1, 5'd0, 4'd0, 1'b0, 1'b0, 7);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_after_abort", 32'(bus.scan_busy), 0);
    for (int a = 0; a < 16; a++) eval(4'(a), 2'b00);
    run_scan(1'b0, 5'd0, 4'd0, 1'b1, 1'b0, 0);

    @(negedge clk);
    #1;
    check("eval_q_drained", 32'(eval_q.size()), 0);
    check("scan_q_drained", 32'(scan_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
